// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, decoded sync/blank strobes and a
// clk-domain frame counter so animation logic never clocks off vsync.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [9:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] pix_x_reg, pix_x_next;
    logic [9:0] pix_y_reg, pix_y_next;
    logic [9:0] frame_count_reg, frame_count_next;
    logic       line_end, hsync_on, vsync_on;

    assign line_end = (pix_x_reg == H_LAST);

    always_comb begin
        pix_x_next       = pix_x_reg;
        pix_y_next       = pix_y_reg;
        frame_count_next = frame_count_reg;
        if (ce) begin
            if (line_end) begin
                pix_x_next = '0;
                pix_y_next = (pix_y_reg == V_LAST) ? 10'd0 : pix_y_reg + 10'd1;
            end else begin
                pix_x_next = pix_x_reg + 10'd1;
            end
            if (frame_tick)
                frame_count_next = frame_count_reg + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            frame_count_reg <= '0;
        end else begin
            pix_x_reg       <= pix_x_next;
            pix_y_reg       <= pix_y_next;
            frame_count_reg <= frame_count_next;
        end
    end

    // Decodes are combinational off the counters so they line up with pix_x/pix_y;
    // gating with reset keeps sync inactive and ticks quiet while reset is held.
    assign hsync_on = (pix_x_reg >= HS_FIRST) && (pix_x_reg <= HS_LAST);
    assign vsync_on = (pix_y_reg >= VS_FIRST) && (pix_y_reg <= VS_LAST);

    assign pix_x        = pix_x_reg;
    assign pix_y        = pix_y_reg;
    assign frame_count  = frame_count_reg;
    assign video_active = !reset && (pix_x_reg < H_VIS) && (pix_y_reg < V_VIS);
    assign hsync        = (!reset && hsync_on) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vsync        = (!reset && vsync_on) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign line_tick    = ce && !reset && line_end;
    assign frame_tick   = ce && !reset && (pix_x_reg == 10'd0) && (pix_y_reg == V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line/ce/reset timing and a tiny
// instance (7x5 raster) for frame timing and frame_count wrap.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    logic       clk;
    logic       reset_b, ce_b, reset_s, ce_s;
    logic [9:0] pix_x_b, pix_y_b, fc_b, pix_x_s, pix_y_s, fc_s;
    logic       va_b, hs_b, vs_b, lt_b, ft_b;
    logic       va_s, hs_s, vs_s, lt_s, ft_s;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    int compared   = 0;
    int mismatched = 0;

    vga_timing_gen u_big (
        .clk(clk), .reset(reset_b), .ce(ce_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .video_active(va_b),
        .hsync(hs_b), .vsync(vs_b), .line_tick(lt_b),
        .frame_tick(ft_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk(clk), .reset(reset_s), .ce(ce_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .video_active(va_s),
        .hsync(hs_s), .vsync(vs_s), .line_tick(lt_s),
        .frame_tick(ft_s), .frame_count(fc_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] act);
        exp_t e;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL sb_underflow observed=%0d expected=queued_entry", act);
        end else begin
            e = sb_q.pop_front();
            $display("check %-14s observed=%0d expected=%0d", e.tag, act, e.exp);
            assert (act === e.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int xerr, hs_cnt, hs_first, va_cnt, lt_cnt, lt_x, bad, ft_cnt, ft_x, ft_y, vs_cnt;
        int mx, my;

        // ---- reset held 3 cycles with ce=1 ----
        reset_b = 1'b1; ce_b = 1'b1; reset_s = 1'b1; ce_s = 1'b1;
        repeat (3) @(posedge clk);
        step();
        sb_push("rst_x", 0);  sb_push("rst_y", 0);  sb_push("rst_fc", 0);
        sb_push("rst_va", 0); sb_push("rst_hs", 1); sb_push("rst_vs", 1);
        sb_push("rst_lt", 0); sb_push("rst_ft", 0);
        sb_check(32'(pix_x_b)); sb_check(32'(pix_y_b)); sb_check(32'(fc_b));
        sb_check(32'(va_b));    sb_check(32'(hs_b));    sb_check(32'(vs_b));
        sb_check(32'(lt_b));    sb_check(32'(ft_b));
        reset_b = 1'b0;
        #1;
        sb_push("rel_va", 1);
        sb_check(32'(va_b));

        // ---- one full line at ce=1 ----
        sb_push("line_xseq", 0); sb_push("line_hs_cnt", 96); sb_push("line_hs_first", 656);
        sb_push("line_va_cnt", 640); sb_push("line_lt_cnt", 1); sb_push("line_lt_x", 799);
        sb_push("line_y", 1); sb_push("line_x", 0);
        xerr = 0; hs_cnt = 0; hs_first = -1; va_cnt = 0; lt_cnt = 0; lt_x = -1;
        for (int i = 0; i < 800; i++) begin
            if (int'(pix_x_b) != i) xerr++;
            if (hs_b === 1'b0) begin
                if (hs_cnt == 0) hs_first = int'(pix_x_b);
                hs_cnt++;
            end
            if (va_b === 1'b1) va_cnt++;
            if (lt_b === 1'b1) begin
                lt_cnt++;
                lt_x = int'(pix_x_b);
            end
            step();
        end
        sb_check(32'(xerr)); sb_check(32'(hs_cnt)); sb_check(32'(hs_first));
        sb_check(32'(va_cnt)); sb_check(32'(lt_cnt)); sb_check(32'(lt_x));
        sb_check(32'(pix_y_b)); sb_check(32'(pix_x_b));

        // ---- ce toggling: one line spans 1600 clocks ----
        sb_push("ce_xseq", 0); sb_push("ce_tick_off", 0); sb_push("ce_lt_cnt", 1);
        sb_push("ce_y", 2); sb_push("ce_x", 0);
        xerr = 0; bad = 0; lt_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            ce_b = (i % 2 == 0);
            #1;
            if (int'(pix_x_b) != ((i + 1) / 2) % 800) xerr++;
            if (!ce_b && (lt_b !== 1'b0 || ft_b !== 1'b0)) bad++;
            if (lt_b === 1'b1) lt_cnt++;
            step();
        end
        ce_b = 1'b1;
        sb_check(32'(xerr)); sb_check(32'(bad)); sb_check(32'(lt_cnt));
        sb_check(32'(pix_y_b)); sb_check(32'(pix_x_b));

        // ---- reset mid-line on the big raster ----
        repeat (300) step();
        sb_push("mid_x", 300); sb_check(32'(pix_x_b));
        reset_b = 1'b1;
        #1;
        sb_push("mid_rst_va", 0); sb_push("mid_rst_hs", 1); sb_push("mid_rst_lt", 0);
        sb_check(32'(va_b)); sb_check(32'(hs_b)); sb_check(32'(lt_b));
        step();
        sb_push("mid_x0", 0); sb_push("mid_y0", 0); sb_push("mid_fc0", 0); sb_push("mid_vs", 1);
        sb_check(32'(pix_x_b)); sb_check(32'(pix_y_b)); sb_check(32'(fc_b)); sb_check(32'(vs_b));
        reset_b = 1'b0;

        // ---- one frame on the small raster (7 x 5) ----
        reset_s = 1'b0;
        #1;
        sb_push("sf_xyseq", 0); sb_push("sf_lt_cnt", 5); sb_push("sf_ft_cnt", 1);
        sb_push("sf_ft_x", 0); sb_push("sf_ft_y", 2); sb_push("sf_vs_cnt", 7);
        sb_push("sf_hs_cnt", 5); sb_push("sf_va_cnt", 8); sb_push("sf_fc", 1);
        sb_push("sf_x_wrap", 0); sb_push("sf_y_wrap", 0);
        xerr = 0; lt_cnt = 0; ft_cnt = 0; ft_x = -1; ft_y = -1; vs_cnt = 0; hs_cnt = 0; va_cnt = 0;
        mx = 0; my = 0;
        for (int i = 0; i < 35; i++) begin
            if (int'(pix_x_s) != mx || int'(pix_y_s) != my) xerr++;
            if (lt_s === 1'b1) lt_cnt++;
            if (ft_s === 1'b1) begin
                ft_cnt++;
                ft_x = int'(pix_x_s);
                ft_y = int'(pix_y_s);
            end
            if (vs_s === 1'b0) vs_cnt++;
            if (hs_s === 1'b0) hs_cnt++;
            if (va_s === 1'b1) va_cnt++;
            if (mx == 6) begin
                mx = 0;
                my = (my == 4) ? 0 : my + 1;
            end else begin
                mx++;
            end
            step();
        end
        sb_check(32'(xerr)); sb_check(32'(lt_cnt)); sb_check(32'(ft_cnt));
        sb_check(32'(ft_x)); sb_check(32'(ft_y)); sb_check(32'(vs_cnt));
        sb_check(32'(hs_cnt)); sb_check(32'(va_cnt)); sb_check(32'(fc_s));
        sb_check(32'(pix_x_s)); sb_check(32'(pix_y_s));

        // ---- reset coinciding with frame_tick clears frame_count ----
        repeat (14) step();
        sb_push("ftr_ft_pre", 1); sb_check(32'(ft_s));
        reset_s = 1'b1;
        #1;
        sb_push("ftr_ft_rst", 0); sb_check(32'(ft_s));
        step();
        sb_push("ftr_fc", 0); sb_push("ftr_x", 0); sb_push("ftr_y", 0);
        sb_check(32'(fc_s)); sb_check(32'(pix_x_s)); sb_check(32'(pix_y_s));
        reset_s = 1'b0;
        #1;

        // ---- frame_count wrap over 1025 frames ----
        ft_cnt = 0;
        for (int i = 0; i < 1023 * 35; i++) begin
            if (ft_s === 1'b1) ft_cnt++;
            step();
        end
        sb_push("wrap_1023", 1023); sb_check(32'(fc_s));
        for (int i = 0; i < 35; i++) begin
            if (ft_s === 1'b1) ft_cnt++;
            step();
        end
        sb_push("wrap_0", 0); sb_check(32'(fc_s));
        for (int i = 0; i < 35; i++) begin
            if (ft_s === 1'b1) ft_cnt++;
            step();
        end
        sb_push("wrap_1", 1); sb_push("wrap_ft_total", 1025);
        sb_check(32'(fc_s)); sb_check(32'(ft_cnt));

        compared++;
        assert (sb_q.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing and the pixel coordinates consumed by the background and sprite renderers.
- Drives pix_x, pix_y, video_active, hsync and vsync for the pixel pipeline.
- Also supplies a single-cycle frame_tick and a free-running frame_count, so downstream animation logic runs on clk instead of using vsync as a clock.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync while asserted (0 = active-low)

Ports:
- clk  input  1  pixel-rate clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  pixel clock enable; counters advance only when high
- pix_x  output  10  horizontal counter, 0..H_TOTAL-1
- pix_y  output  10  vertical counter, 0..V_TOTAL-1
- video_active  output  1  high inside the visible area
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- line_tick  output  1  one-cycle pulse on the last pixel of each line
- frame_tick  output  1  one-cycle pulse at the start of vertical blank
- frame_count  output  10  frame counter, wraps modulo 1024

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525)
- Reset, sampled on the clk rising edge while reset=1:
  - pix_x=0, pix_y=0, frame_count=0
  - while reset is high: video_active=0, hsync=vsync=!SYNC_ACTIVE, line_tick=frame_tick=0
- Counting, on each edge with ce=1 and reset=0:
  - if pix_x==H_TOTAL-1: pix_x<=0, and pix_y<=(pix_y==V_TOTAL-1)?0:pix_y+1
  - else pix_x<=pix_x+1
- ce=0: all registers hold; line_tick=frame_tick=0.
- Decoded outputs are aligned to the current pix_x/pix_y, with no pipeline skew:
  - video_active = (pix_x<H_VISIBLE) && (pix_y<V_VISIBLE)
  - hsync = SYNC_ACTIVE when pix_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751
  - vsync = SYNC_ACTIVE when pix_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491
  - line_tick = ce && pix_x==H_TOTAL-1
  - frame_tick = ce && pix_x==0 && pix_y==V_VISIBLE
- frame_count increments by 1 on the edge where frame_tick=1; the new value is visible the following cycle. It wraps from 1023 to 0.
- Simultaneous events:
  - At (H_TOTAL-1, V_TOTAL-1): line_tick=1, and both counters return to 0 on the same edge.
  - frame_tick and line_tick can never coincide.
- Reset mid-frame: the next cycle shows (0,0). No partial sync pulse continues; hsync/vsync are inactive during reset.
- Widths: pix_x/pix_y are 10-bit unsigned. Parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024.

Test Plan:
- Reset: hold reset 3 cycles with ce=1 -> pix_x=0, pix_y=0, frame_count=0, video_active=0, hsync=vsync=1, ticks 0. After release, video_active=1 at (0,0).
- Line timing: ce=1 for one line -> hsync low for exactly 96 cycles starting at pix_x=656; video_active high for 640 cycles; line_tick once at pix_x=799; pix_y 0->1.
- Frame timing: run 420000 cycles -> 525 line_ticks; vsync low exactly for pix_y 490..491 (1600 cycles); frame_tick once at (0,480); frame_count 0->1; wrap returns to (0,0).
- Clock enable: ce toggling 1/0 -> one line takes 1600 clk cycles; no tick is asserted while ce=0; counters hold.
- Reset mid-frame: assert reset at (300,200) -> (0,0) next cycle. frame_count clears even if frame_tick was asserted in the same cycle.
- Wrap: reduced params (H_VISIBLE=4, other H porches=1, V_VISIBLE=2, other V porches=1) run for 1025 frames -> frame_count reads 1023 then 0 then 1.
